// File: rtl/riscv_pkg.sv
// Shared RV32 definitions used by the iterative divider.
package riscv_pkg;

   localparam int unsigned XLEN  = 32;
   localparam int unsigned CNT_W = $clog2(XLEN);

   typedef enum logic [1:0] {
      DIV  = 2'b00,
      DIVU = 2'b01,
      REM  = 2'b10,
      REMU = 2'b11
   } div_op_e;

   typedef enum logic [1:0] {
      IDLE,
      CALC,
      FIN,
      DONE
   } div_state_e;

endpackage

// File: rtl/div_sequencer_step.sv
// One restoring-division iteration: shift {rem, quo} left, trial-subtract divisor.
module div_step
   import riscv_pkg::*;
(
   input  logic [XLEN-1:0] rem_i,
   input  logic [XLEN-1:0] quo_i,
   input  logic [XLEN-1:0] dvs_i,
   output logic [XLEN-1:0] rem_o,
   output logic [XLEN-1:0] quo_o
);

   logic [XLEN:0] partial;
   logic [XLEN:0] diff;

   always_comb begin
      partial = {rem_i, quo_i[XLEN-1]};
      // partial < 2*divisor, so a non-negative difference always fits XLEN bits
      diff    = partial - {1'b0, dvs_i};
      if (!diff[XLEN]) begin
         rem_o = diff[XLEN-1:0];
         quo_o = {quo_i[XLEN-2:0], 1'b1};
      end else begin
         rem_o = partial[XLEN-1:0];
         quo_o = {quo_i[XLEN-2:0], 1'b0};
      end
   end

endmodule

// File: rtl/div_sequencer.sv
// RV32M DIV/DIVU/REM/REMU controller: 32-step restoring divide with sign fix-up,
// divide-by-zero and signed-overflow fast paths, pipeline stall and flush handling.
module div_sequencer
   import riscv_pkg::*;
(
   input  logic            clk,
   input  logic            rst_n,
   input  logic            start_valid,
   output logic            start_ready,
   input  logic [1:0]      op,
   input  logic [XLEN-1:0] dividend,
   input  logic [XLEN-1:0] divisor,
   input  logic            flush,
   output logic            busy,
   output logic            stall,
   output logic            done,
   output logic [XLEN-1:0] result
);

   localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(XLEN - 1);

   div_state_e       state_q, state_d;
   div_op_e          op_q, op_d;
   logic [XLEN-1:0]  quo_q, quo_d;
   logic [XLEN-1:0]  rem_q, rem_d;
   logic [XLEN-1:0]  dvs_q, dvs_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             q_neg_q, q_neg_d;
   logic             r_neg_q, r_neg_d;
   logic [XLEN-1:0]  result_q, result_d;

   logic [XLEN-1:0]  step_rem, step_quo;
   logic             accept, signed_op, div_zero, ovf;
   logic [XLEN-1:0]  dvd_abs, dvs_abs;
   logic [XLEN-1:0]  sel_val;
   logic             sel_neg;

   div_step u_step (
      .rem_i (rem_q),
      .quo_i (quo_q),
      .dvs_i (dvs_q),
      .rem_o (step_rem),
      .quo_o (step_quo)
   );

   assign done        = (state_q == DONE);
   assign busy        = (state_q != IDLE);
   assign start_ready = (state_q == IDLE) & ~done & ~flush;
   assign stall       = start_valid & ~done;
   assign result      = result_q;

   always_comb begin
      state_d  = state_q;
      op_d     = op_q;
      quo_d    = quo_q;
      rem_d    = rem_q;
      dvs_d    = dvs_q;
      cnt_d    = cnt_q;
      q_neg_d  = q_neg_q;
      r_neg_d  = r_neg_q;
      result_d = result_q;

      accept    = start_valid & start_ready;
      signed_op = ~op[0];
      dvd_abs   = (signed_op && dividend[XLEN-1]) ? -dividend : dividend;
      dvs_abs   = (signed_op && divisor[XLEN-1])  ? -divisor  : divisor;
      div_zero  = (divisor == '0);
      ovf       = signed_op && (dividend == {1'b1, {(XLEN-1){1'b0}}}) && (divisor == '1);

      sel_val = (op_q == REM || op_q == REMU) ? rem_q : quo_q;
      sel_neg = (op_q == REM || op_q == REMU) ? r_neg_q : q_neg_q;

      unique case (state_q)
         IDLE: begin
            if (accept) begin
               op_d    = div_op_e'(op);
               quo_d   = dvd_abs;
               dvs_d   = dvs_abs;
               rem_d   = '0;
               cnt_d   = CNT_MAX;
               q_neg_d = signed_op & (dividend[XLEN-1] ^ divisor[XLEN-1]);
               r_neg_d = signed_op & dividend[XLEN-1];
               if (div_zero) begin
                  result_d = op[1] ? dividend : '1;
                  state_d  = DONE;
               end else if (ovf) begin
                  result_d = op[1] ? '0 : dividend;
                  state_d  = DONE;
               end else begin
                  state_d  = CALC;
               end
            end
         end
         CALC: begin
            rem_d = step_rem;
            quo_d = step_quo;
            if (cnt_q == '0) begin
               state_d = FIN;
            end else begin
               cnt_d = cnt_q - 1'b1;
            end
         end
         FIN: begin
            result_d = sel_neg ? -sel_val : sel_val;
            state_d  = DONE;
         end
         DONE: begin
            state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase

      // done in the DONE cycle is driven from state, so flush cannot suppress it
      if (flush) begin
         state_d  = IDLE;
         cnt_d    = '0;
         result_d = result_q;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q  <= IDLE;
         op_q     <= DIV;
         quo_q    <= '0;
         rem_q    <= '0;
         dvs_q    <= '0;
         cnt_q    <= '0;
         q_neg_q  <= 1'b0;
         r_neg_q  <= 1'b0;
         result_q <= '0;
      end else begin
         state_q  <= state_d;
         op_q     <= op_d;
         quo_q    <= quo_d;
         rem_q    <= rem_d;
         dvs_q    <= dvs_d;
         cnt_q    <= cnt_d;
         q_neg_q  <= q_neg_d;
         r_neg_q  <= r_neg_d;
         result_q <= result_d;
      end
   end

endmodule

// File: tb/tb_div_sequencer.sv
// Self-checking bench for div_sequencer against an arithmetic RV32M reference.
module tb_div_sequencer;

   logic        clk;
   logic        rst_n;
   logic        start_valid;
   logic        start_ready;
   logic [1:0]  op;
   logic [31:0] dividend;
   logic [31:0] divisor;
   logic        flush;
   logic        busy;
   logic        stall;
   logic        done;
   logic [31:0] result;

   int checks   = 0;
   int failures = 0;

   div_sequencer dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .start_valid (start_valid),
      .start_ready (start_ready),
      .op          (op),
      .dividend    (dividend),
      .divisor     (divisor),
      .flush       (flush),
      .busy        (busy),
      .stall       (stall),
      .done        (done),
      .result      (result)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   // RV32M semantics computed directly from the ISA rules
   function automatic logic [31:0] ref_result(input logic [1:0] o, input logic [31:0] a,
                                              input logic [31:0] b);
      logic [31:0] q;
      logic [31:0] r;
      if (b == 32'd0) begin
         q = 32'hFFFF_FFFF;
         r = a;
      end else if (!o[0]) begin
         if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
            q = a;
            r = 32'd0;
         end else begin
            q = 32'($signed(a) / $signed(b));
            r = 32'($signed(a) % $signed(b));
         end
      end else begin
         q = a / b;
         r = a % b;
      end
      return o[1] ? r : q;
   endfunction

   function automatic int ref_latency(input logic [1:0] o, input logic [31:0] a,
                                      input logic [31:0] b);
      if (b == 32'd0) return 1;
      if (!o[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 1;
      return 34;
   endfunction

   // Issues one operation with start_valid held until done; scrambles operands after accept.
   task automatic issue(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                        output int lat, output logic [31:0] res,
                        output int bad_stall, output int bad_ready);
      @(posedge clk); #1;
      op = o; dividend = a; divisor = b; start_valid = 1'b1;
      @(negedge clk);
      bad_ready = start_ready ? 0 : 1;
      bad_stall = stall ? 0 : 1;
      lat = -1;
      res = 32'd0;
      for (int k = 1; k <= 60 && lat < 0; k++) begin
         @(posedge clk); #1;
         op       = 2'($urandom);
         dividend = $urandom;
         divisor  = $urandom;
         @(negedge clk);
         if (done) begin
            lat = k;
            res = result;
            if (start_ready) bad_ready++;
            if (stall) bad_stall++;
         end else if (!stall) begin
            bad_stall++;
         end
      end
      @(posedge clk); #1;
      start_valid = 1'b0;
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      start_valid = 1'b0; flush = 1'b0; op = 2'd0; dividend = '0; divisor = '0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      checks++; if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b exp=0", busy); end
      checks++; if (done !== 1'b0) begin failures++; $display("FAIL reset_done got=%b exp=0", done); end
      checks++; if (result !== 32'd0) begin failures++; $display("FAIL reset_result got=%h exp=0", result); end
      checks++; if (stall !== 1'b0) begin failures++; $display("FAIL reset_stall got=%b exp=0", stall); end
      @(posedge clk); #1;
      rst_n = 1'b1;
      @(negedge clk);
      checks++; if (start_ready !== 1'b1) begin failures++; $display("FAIL idle_ready got=%b exp=1", start_ready); end
   endtask

   logic [1:0]  d_op  [12] = '{2'd0, 2'd2, 2'd0, 2'd2, 2'd1, 2'd1, 2'd3, 2'd0, 2'd0, 2'd2, 2'd1, 2'd2};
   logic [31:0] d_a   [12] = '{32'd100, 32'd100, 32'hFFFFFFF9, 32'hFFFFFFF9, 32'hFFFFFFF9,
                               32'h12345678, 32'h12345678, 32'd5, 32'h80000000, 32'h80000000,
                               32'h80000000, 32'hFFFFFFF9};
   logic [31:0] d_b   [12] = '{32'd7, 32'd7, 32'd2, 32'd2, 32'd2, 32'd0, 32'd0, 32'd0,
                               32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'd0};
   logic [31:0] d_exp [12] = '{32'd14, 32'd2, 32'hFFFFFFFD, 32'hFFFFFFFF, 32'h7FFFFFFC,
                               32'hFFFFFFFF, 32'h12345678, 32'hFFFFFFFF, 32'h80000000, 32'd0,
                               32'd0, 32'hFFFFFFF9};
   int          d_lat [12] = '{34, 34, 34, 34, 34, 1, 1, 1, 1, 1, 34, 1};

   task automatic test_directed();
      int lat, bs, br;
      logic [31:0] res;
      for (int i = 0; i < 12; i++) begin
         issue(d_op[i], d_a[i], d_b[i], lat, res, bs, br);
         checks++;
         if (res !== d_exp[i]) begin
            failures++; $display("FAIL directed_result[%0d] got=%h exp=%h", i, res, d_exp[i]);
         end
         checks++;
         if (lat != d_lat[i]) begin
            failures++; $display("FAIL directed_latency[%0d] got=%0d exp=%0d", i, lat, d_lat[i]);
         end
         checks++;
         if (bs != 0) begin
            failures++; $display("FAIL directed_stall[%0d] bad_cycles=%0d exp=0", i, bs);
         end
         checks++;
         if (br != 0) begin
            failures++; $display("FAIL directed_ready[%0d] bad_cycles=%0d exp=0", i, br);
         end
      end
   endtask

   task automatic test_random();
      int lat, bs, br, mode;
      logic [1:0]  o;
      logic [31:0] a, b, res;
      for (int i = 0; i < 24; i++) begin
         o    = 2'($urandom_range(0, 3));
         a    = $urandom;
         mode = $urandom_range(0, 5);
         case (mode)
            0:       b = 32'd0;
            1:       b = 32'($urandom_range(1, 15));
            2:       begin b = 32'hFFFF_FFFF; if ($urandom_range(0, 1) == 1) a = 32'h8000_0000; end
            3:       begin a = 32'($urandom_range(0, 1000)); b = $urandom; end
            default: b = $urandom;
         endcase
         issue(o, a, b, lat, res, bs, br);
         checks++;
         if (res !== ref_result(o, a, b)) begin
            failures++;
            $display("FAIL random_result op=%0d a=%h b=%h got=%h exp=%h", o, a, b, res, ref_result(o, a, b));
         end
         checks++;
         if (lat != ref_latency(o, a, b)) begin
            failures++; $display("FAIL random_latency got=%0d exp=%0d", lat, ref_latency(o, a, b));
         end
         checks++;
         if (bs != 0 || br != 0) begin
            failures++; $display("FAIL random_handshake stall_bad=%0d ready_bad=%0d exp=0", bs, br);
         end
      end
   endtask

   task automatic test_flush();
      int lat, bs, br, seen;
      logic [31:0] res;
      issue(2'd1, 32'd1000, 32'd10, lat, res, bs, br);
      checks++; if (res !== 32'd100) begin failures++; $display("FAIL flush_setup got=%h exp=%h", res, 32'd100); end

      @(posedge clk); #1;
      op = 2'd0; dividend = $urandom; divisor = 32'd7; start_valid = 1'b1;
      @(negedge clk);
      seen = 0;
      for (int k = 1; k <= 10; k++) begin
         @(posedge clk); #1;
         if (k == 10) begin flush = 1'b1; start_valid = 1'b0; end
         @(negedge clk);
         if (done) seen++;
      end
      @(posedge clk); #1;
      flush = 1'b0;
      @(negedge clk);
      checks++; if (busy !== 1'b0) begin failures++; $display("FAIL flush_busy got=%b exp=0", busy); end
      checks++; if (result !== 32'd100) begin failures++; $display("FAIL flush_result got=%h exp=%h", result, 32'd100); end
      for (int k = 0; k < 40; k++) begin
         @(negedge clk);
         if (done) seen++;
      end
      checks++; if (seen != 0) begin failures++; $display("FAIL flush_no_done got=%0d exp=0", seen); end

      issue(2'd1, 32'd9, 32'd3, lat, res, bs, br);
      checks++; if (res !== 32'd3) begin failures++; $display("FAIL after_flush_result got=%h exp=3", res); end
      checks++; if (lat != 34) begin failures++; $display("FAIL after_flush_latency got=%0d exp=34", lat); end

      @(posedge clk); #1;
      start_valid = 1'b1; flush = 1'b1; op = 2'd1; dividend = 32'd50; divisor = 32'd5;
      @(negedge clk);
      checks++; if (start_ready !== 1'b0) begin failures++; $display("FAIL flush_idle_ready got=%b exp=0", start_ready); end
      @(posedge clk); #1;
      start_valid = 1'b0; flush = 1'b0;
      @(negedge clk);
      checks++; if (busy !== 1'b0) begin failures++; $display("FAIL flush_idle_accept busy=%b exp=0", busy); end

      @(posedge clk); #1;
      start_valid = 1'b1; op = 2'd1; dividend = 32'd7; divisor = 32'd0;
      @(negedge clk);
      @(posedge clk); #1;
      flush = 1'b1;
      @(negedge clk);
      checks++; if (done !== 1'b1) begin failures++; $display("FAIL flush_in_done got=%b exp=1", done); end
      checks++; if (result !== 32'hFFFF_FFFF) begin failures++; $display("FAIL flush_in_done_result got=%h exp=ffffffff", result); end
      @(posedge clk); #1;
      flush = 1'b0; start_valid = 1'b0;
      @(negedge clk);
   endtask

   task automatic test_reset_mid_op();
      @(posedge clk); #1;
      op = 2'd0; dividend = 32'd12345; divisor = 32'd17; start_valid = 1'b1;
      @(negedge clk);
      repeat (5) @(posedge clk);
      #3;
      rst_n = 1'b0; start_valid = 1'b0;
      #1;
      checks++; if (busy !== 1'b0) begin failures++; $display("FAIL midreset_busy got=%b exp=0", busy); end
      checks++; if (done !== 1'b0) begin failures++; $display("FAIL midreset_done got=%b exp=0", done); end
      checks++; if (result !== 32'd0) begin failures++; $display("FAIL midreset_result got=%h exp=0", result); end
      checks++; if (stall !== 1'b0) begin failures++; $display("FAIL midreset_stall got=%b exp=0", stall); end
      @(posedge clk); #1;
      rst_n = 1'b1;
      @(negedge clk);
   endtask

   task automatic test_back_to_back();
      int acc[$];
      int dcyc[$];
      logic [31:0] dres[$];
      int dones, extra;
      @(posedge clk); #1;
      op = 2'd3; dividend = 32'd17; divisor = 32'd5; start_valid = 1'b1;
      dones = 0;
      for (int cyc = 0; cyc < 100 && dones < 2; cyc++) begin
         @(negedge clk);
         if (start_valid && start_ready) acc.push_back(cyc);
         if (done) begin dcyc.push_back(cyc); dres.push_back(result); dones++; end
         @(posedge clk); #1;
         if (dones == 1) begin dividend = 32'hFFFF_FFFF; divisor = 32'd16; end
      end
      start_valid = 1'b0;
      extra = 0;
      for (int k = 0; k < 6; k++) begin
         @(negedge clk);
         if (done) extra++;
      end
      checks++; if (dones != 2) begin failures++; $display("FAIL b2b_done_count got=%0d exp=2", dones); end
      checks++; if (extra != 0) begin failures++; $display("FAIL b2b_extra_done got=%0d exp=0", extra); end
      checks++;
      if (acc.size() != 2) begin
         failures++; $display("FAIL b2b_accept_count got=%0d exp=2", acc.size());
      end else if (acc[0] != 0 || acc[1] != 35) begin
         failures++; $display("FAIL b2b_accept_cycles got=%0d,%0d exp=0,35", acc[0], acc[1]);
      end
      if (dones == 2) begin
         checks++;
         if (dcyc[0] != 34 || dcyc[1] != 69) begin
            failures++; $display("FAIL b2b_done_cycles got=%0d,%0d exp=34,69", dcyc[0], dcyc[1]);
         end
         checks++; if (dres[0] !== 32'd2) begin failures++; $display("FAIL b2b_result0 got=%h exp=2", dres[0]); end
         checks++; if (dres[1] !== 32'd15) begin failures++; $display("FAIL b2b_result1 got=%h exp=f", dres[1]); end
      end
   endtask

   initial begin
      test_reset();
      test_directed();
      test_random();
      test_flush();
      test_reset_mid_op();
      test_back_to_back();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
